// File: rtl/mfcc_melbank_acc_if.sv
// mfcc_melbank_acc_if: power-bin stream, coefficient ROM port and mel-energy stream
interface mfcc_melbank_acc_if #(
  parameter int PWR_W  = 32,
  parameter int COEF_W = 8,
  parameter int ADDR_W = 9,
  parameter int OUT_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [PWR_W-1:0]  in_data;
  logic              in_last;
  logic [ADDR_W-1:0] rom_addr;
  logic [COEF_W-1:0] rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              frame_err;
  modport master (
    output in_valid, in_data, in_last, rom_data, out_ready,
    input  in_ready, rom_addr, out_valid, out_data, frame_err
  );
  modport slave (
    input  in_valid, in_data, in_last, rom_data, out_ready,
    output in_ready, rom_addr, out_valid, out_data, frame_err
  );
endinterface

// File: rtl/mfcc_melbank_acc.sv
// mfcc_melbank_acc: weights power bins by ROM coefficients and emits one saturated mel energy per frame
module mfcc_melbank_acc #(
  parameter int BIN_NUM   = 257,
  parameter int ADDR_W    = 9,
  parameter int PWR_W     = 32,
  parameter int COEF_W    = 8,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 8
) (
  input logic clk,
  input logic rst_n,
  mfcc_melbank_acc_if.slave bus
);
  localparam int PRD_W = PWR_W + COEF_W;
  localparam int ACC_W = PRD_W + ADDR_W;
  localparam logic [ACC_W-1:0] SAT = ACC_W'({OUT_W{1'b1}});
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;
  state_t state, state_nx;
  logic run, drn, pv, err, accept, last_bin, close;
  logic [ADDR_W-1:0] bin_cnt;
  logic [PRD_W-1:0] prod;
  logic [ACC_W-1:0] acc, acc_sh;
  logic [OUT_W-1:0] out_q;
  assign last_bin = bin_cnt == ADDR_W'(BIN_NUM - 1);
  assign acc_sh = acc >> OUT_SHIFT;
  assign bus.rom_addr = bin_cnt;
  assign bus.out_valid = state == OUT;
  assign bus.out_data = out_q;
  assign bus.frame_err = err;
  // handshake decode and frame sequencing: a frame closes on in_last or on its final bin
  always_comb begin
    state_nx = state;
    bus.in_ready = run && (state == IDLE || state == ACC);
    accept = bus.in_valid && bus.in_ready;
    close = accept && (bus.in_last || last_bin);
    case (state)
      IDLE:    state_nx = accept ? (close ? DRAIN : ACC) : IDLE;
      ACC:     state_nx = close ? DRAIN : ACC;
      DRAIN:   state_nx = drn ? OUT : DRAIN;
      OUT:     state_nx = bus.out_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end
  // state register; run holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run <= 1'b0;
    end else begin
      state <= state_nx;
      run <= 1'b1;
    end
  end
  // multiply stage, accumulate stage, drain timer, saturating output and sticky length error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt <= '0;
      prod <= '0;
      pv <= 1'b0;
      acc <= '0;
      drn <= 1'b0;
      out_q <= '0;
      err <= 1'b0;
    end else begin
      bin_cnt <= close ? '0 : accept ? bin_cnt + 1'b1 : bin_cnt;
      pv <= accept;
      if (accept) prod <= PRD_W'(bus.in_data) * PRD_W'(bus.rom_data);
      acc <= (state == OUT && bus.out_ready) ? '0 : pv ? acc + ACC_W'(prod) : acc;
      drn <= state == DRAIN && !drn;
      if (state == DRAIN && drn) out_q <= acc_sh > SAT ? {OUT_W{1'b1}} : acc_sh[OUT_W-1:0];
      err <= err || (accept && (bus.in_last != last_bin));
    end
  end
endmodule

// File: tb/tb_mfcc_melbank_acc.sv
// tb_mfcc_melbank_acc: directed checks of mel filter accumulation, backpressure, frame errors and reset
module tb_mfcc_melbank_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_cnt = 0;
  int total = 0;
  int rom_mode = 0;
  logic [31:0] got[$];
  always #5 clk = ~clk;
  mfcc_melbank_acc_if bus();
  mfcc_melbank_acc dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  // coefficient ROM model: all 255, or weight = low address byte
  assign bus.rom_data = (rom_mode == 1) ? bus.rom_addr[7:0] : 8'd255;
  // capture every output handshake (completes at the following rising edge)
  always @(negedge clk) if (rst_n && bus.out_valid && bus.out_ready) got.push_back(bus.out_data);

  task automatic beat(input logic [31:0] d, input logic l, output logic [8:0] a);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      $display("FAIL beat_timeout in_ready=%0b required=1", bus.in_ready);
    end
    a = bus.rom_addr;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic frame(input int n, input logic [31:0] d);
    logic [8:0] a;
    for (int i = 0; i < n; i++) beat(d, i == n - 1, a);
  endtask

  task automatic wait_out(output logic [31:0] v);
    int n = 0;
    while (got.size() == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (got.size() == 0) begin
      total++;
      $display("FAIL out_timeout handshakes=0 required=1");
      v = 32'hx;
    end else v = got.pop_front();
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (!bus.out_valid) $display("FAIL valid_timeout out_valid=0 required=1");
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); else pass_cnt++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); else pass_cnt++;
    total++; if (bus.out_data !== 32'd0) $display("FAIL rst_out_data got=%0h exp=0", bus.out_data); else pass_cnt++;
    total++; if (bus.frame_err !== 1'b0) $display("FAIL rst_frame_err got=%0b exp=0", bus.frame_err); else pass_cnt++;
    total++; if (bus.rom_addr !== 9'd0) $display("FAIL rst_rom_addr got=%0d exp=0", bus.rom_addr); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL rel_in_ready_early got=%0b exp=0", bus.in_ready); else pass_cnt++;
    @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rel_in_ready got=%0b exp=1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_single_frame();
    logic [8:0] a;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) beat(32'd1, 1'b0, a);
    beat(32'd1, 1'b1, a);
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL lat_t1 out_valid=%0b in_ready=%0b exp=0/0", bus.out_valid, bus.in_ready); else pass_cnt++;
    @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL lat_t2 out_valid=%0b exp=0", bus.out_valid); else pass_cnt++;
    @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL lat_t3 out_valid=%0b exp=1", bus.out_valid); else pass_cnt++;
    total++; if (bus.out_data !== 32'd255) $display("FAIL single_data got=%0d exp=255", bus.out_data); else pass_cnt++;
    total++; if (bus.frame_err !== 1'b0) $display("FAIL single_err got=%0b exp=0", bus.frame_err); else pass_cnt++;
    @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL single_hs out_valid=%0b in_ready=%0b exp=0/1", bus.out_valid, bus.in_ready); else pass_cnt++;
    got.delete();
  endtask

  task automatic test_weighted();
    logic [8:0] a;
    logic [63:0] e = 64'd0;
    logic [31:0] v;
    logic addr_ok = 1'b1;
    rom_mode = 1;
    for (int i = 0; i < 257; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        if (bus.rom_addr !== 9'(i)) addr_ok = 1'b0;
      end
      beat(32'd1 << (i % 4), i == 256, a);
      if (a !== 9'(i)) addr_ok = 1'b0;
      e += 64'(i % 256) << (i % 4);
    end
    wait_out(v);
    e = e >> 8;
    total++; if (v !== e[31:0]) $display("FAIL weighted_data got=%0d exp=%0d", v, e[31:0]); else pass_cnt++;
    total++; if (addr_ok !== 1'b1) $display("FAIL weighted_addr got=%0b exp=1", addr_ok); else pass_cnt++;
    total++; if (bus.rom_addr !== 9'd0) $display("FAIL weighted_addr_rst got=%0d exp=0", bus.rom_addr); else pass_cnt++;
    rom_mode = 0;
  endtask

  task automatic test_saturation();
    logic [31:0] v;
    frame(257, 32'hFFFF_FFFF);
    wait_out(v);
    total++; if (v !== 32'hFFFF_FFFF) $display("FAIL saturate got=%0h exp=ffffffff", v); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic stable = 1'b1;
    bus.out_ready = 1'b0;
    frame(257, 32'd1);
    wait_valid();
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd255 || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    total++; if (stable !== 1'b1) $display("FAIL hold_stable got=%0b exp=1", stable); else pass_cnt++;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL hold_release out_valid=%0b in_ready=%0b exp=0/1", bus.out_valid, bus.in_ready); else pass_cnt++;
    total++; if (got.size() !== 1) $display("FAIL hold_handshakes got=%0d exp=1", got.size()); else pass_cnt++;
    total++; if (got[0] !== 32'd255) $display("FAIL hold_data got=%0d exp=255", got[0]); else pass_cnt++;
    got.delete();
    frame(257, 32'd2);
    wait_out(v);
    total++; if (v !== 32'd511) $display("FAIL b2b_data got=%0d exp=511", v); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    logic [8:0] a;
    logic [31:0] v;
    frame(101, 32'd1);
    wait_out(v);
    total++; if (v !== 32'd100) $display("FAIL short_data got=%0d exp=100", v); else pass_cnt++;
    total++; if (bus.frame_err !== 1'b1) $display("FAIL short_err got=%0b exp=1", bus.frame_err); else pass_cnt++;
    for (int i = 0; i < 300; i++) beat(32'd1, 1'b0, a);
    beat(32'd1, 1'b1, a);
    wait_out(v);
    total++; if (v !== 32'd255) $display("FAIL force_close_data got=%0d exp=255", v); else pass_cnt++;
    wait_out(v);
    total++; if (v !== 32'd43) $display("FAIL carry_frame_data got=%0d exp=43", v); else pass_cnt++;
    total++; if (bus.frame_err !== 1'b1) $display("FAIL err_sticky got=%0b exp=1", bus.frame_err); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [8:0] a;
    logic [31:0] v;
    for (int i = 0; i < 150; i++) beat(32'd1, 1'b0, a);
    rst_n = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.frame_err !== 1'b0 || bus.rom_addr !== 9'd0)
      $display("FAIL midframe_rst rdy=%0b vld=%0b data=%0h err=%0b addr=%0d exp=all0", bus.in_ready, bus.out_valid, bus.out_data, bus.frame_err, bus.rom_addr);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame(257, 32'd1);
    wait_out(v);
    total++; if (v !== 32'd255) $display("FAIL post_rst_data got=%0d exp=255", v); else pass_cnt++;
    bus.out_ready = 1'b0;
    frame(257, 32'd1);
    wait_valid();
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.in_ready !== 1'b0)
      $display("FAIL out_rst vld=%0b data=%0h rdy=%0b exp=0/0/0", bus.out_valid, bus.out_data, bus.in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (got.size() !== 0 || bus.out_valid !== 1'b0) $display("FAIL out_rst_pulse handshakes=%0d vld=%0b exp=0/0", got.size(), bus.out_valid); else pass_cnt++;
    frame(257, 32'd1);
    wait_out(v);
    total++; if (v !== 32'd255) $display("FAIL clean_data got=%0d exp=255", v); else pass_cnt++;
    total++; if (bus.frame_err !== 1'b0) $display("FAIL clean_err got=%0b exp=0", bus.frame_err); else pass_cnt++;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_weighted();
    test_saturation();
    test_back_to_back();
    test_frame_err();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mfcc_melbank_acc.md
Name: mfcc_melbank_acc

Overview:
- Mel filter accumulation stage directly downstream of one mel filterbank coefficient ROM (9-bit address, 8-bit unsigned weight, combinational read).
- Consumes the power-spectrum stream from the FFT/|X|² stage one bin per beat and drives the ROM address with the bin index.
- Multiplies each bin's power by the ROM weight and accumulates over the frame.
- Emits one saturated mel-band energy per frame to the log/DCT stage via valid/ready.

Parameters:
BIN_NUM, 257, power-spectrum bins per frame (512-point FFT)
ADDR_W, 9, ROM address width; BIN_NUM <= 2^ADDR_W
PWR_W, 32, unsigned power sample width
COEF_W, 8, unsigned ROM weight width, Q0.8
OUT_W, 32, output energy width
OUT_SHIFT, 8, right shift applied to accumulator before saturation

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  power bin valid
in_ready  out  1  block accepts bin when in_valid & in_ready
in_data  in  PWR_W  power of current bin
in_last  in  1  marks final bin of frame
rom_addr  out  ADDR_W  address to coefficient ROM (= current bin index)
rom_data  in  COEF_W  ROM weight, valid same cycle as rom_addr (combinational ROM)
out_valid  out  1  mel energy valid
out_ready  in  1  downstream accepts energy
out_data  out  OUT_W  mel-band energy
frame_err  out  1  sticky: frame length mismatch since reset

Behaviour:
- Reset: clk and rst_n only (one clock; reset is asynchronous and active-low). While rst_n=0 all state cleared: state=IDLE, bin_cnt=0, rom_addr=0, acc=0, pipeline valids=0, in_ready=0, out_valid=0, out_data=0, frame_err=0. in_ready rises first clock edge after release.
- rom_addr is combinational = bin_cnt, so rom_data pairs with the in_data beat presented in the same cycle.
- States: IDLE, ACC, DRAIN, OUT.
- IDLE: in_ready=1, acc=0. First accepted beat -> ACC (beat is processed, bin_cnt -> 1).
- ACC: in_ready=1. Each accepted beat increments bin_cnt. No acceptance when in_valid=0; gaps allowed, no state change.
- Accepted beat with in_last=1 -> DRAIN; bin_cnt resets to 0.
- Pipeline stage 1: product register = in_data*rom_data, PWR_W+COEF_W bits, unsigned.
- Pipeline stage 2: acc += product. acc width PWR_W+COEF_W+ADDR_W, cannot overflow.
- DRAIN: in_ready=0; 2 cycles to flush both stages.
- Then out_data = min(acc >> OUT_SHIFT, 2^OUT_W-1) registered, out_valid=1, -> OUT.
- Latency: last beat accepted at cycle T -> out_valid high at T+3.
- OUT: in_ready=0. out_valid and out_data held stable until out_ready=1. On handshake, in that same edge: out_valid=0, acc=0, state -> IDLE. in_ready=1 the next cycle.
- out_ready is ignored while out_valid=0.
- frame_err set when in_last arrives with bin index != BIN_NUM-1.
- frame_err also set when bin index BIN_NUM-1 is accepted without in_last. The frame is then force-closed as if last (-> DRAIN); following beats belong to the next frame.
- frame_err clears only on reset.
- Single-bin frame (first beat has in_last): IDLE -> DRAIN directly; frame_err set unless BIN_NUM=1.
- Reset mid-frame or while OUT: everything discarded, no output pulse.

Test Plan:
1. ROM model all weights 255, 257 beats in_data=1, last on beat 257, out_ready=1 -> acc=65535, out_data=255 at T+3, frame_err=0.
2. ROM weight = address[7:0]; in_data=2^k pattern; random in_valid gaps -> out_data matches software model bit-exact, rom_addr steps 0..256 only on accepted beats.
3. in_data=0xFFFFFFFF, weights 255, 257 bins -> out_data=0xFFFFFFFF (saturated).
4. out_ready held 0 for 20 cycles -> out_valid/out_data stable, in_ready=0 throughout; release -> one handshake, in_ready=1 next cycle; back-to-back second frame correct.
5. in_last on bin 100 -> frame closed, output = sum of bins 0..100, frame_err=1. Then 300-beat stream without last -> frame closed at bin 256, remaining 43 beats start the next frame.
6. Assert rst_n=0 at bin 150 and again during OUT -> all outputs 0 immediately. Subsequent clean frame gives the same result as scenario 1.
